ahb_slave_arbiter: RTL and testbench

Per-slave AHB arbiter that owns the one-hot select of the slave-side payload multiplexer. It chooses which master's address/control drives one slave port, holds that choice across bursts and locked sequences, and produces a one-cycle-delayed data-phase select for write data and response steering. One instance sits beside each slave-port mux in the generated interconnect, between the master-side decoders and the slave.

---
 rtl/ahb_slave_arbiter.sv | 132 +++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: owns the one-hot address-phase select of the slave
// payload mux and a one-transfer-delayed data-phase select. Holds ownership
// across bursts and locked sequences. Optionally preempts a long-running
// owner at its next NONSEQ boundary.
module ahb_slave_arbiter #(
    parameter int CHANNEL_NUM = 2,
    parameter int RR_EN       = 1,
    parameter int MAX_BEATS   = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [CHANNEL_NUM-1:0]   req,
    input  logic [2*CHANNEL_NUM-1:0] htrans,
    input  logic [CHANNEL_NUM-1:0]   hmastlock,
    input  logic                     hready_in,
    output logic [CHANNEL_NUM-1:0]   sel_addr,
    output logic [CHANNEL_NUM-1:0]   sel_data,
    output logic                     owner_valid
);

    localparam int PW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          owner_q, owner_d;
    logic [PW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CHANNEL_NUM-1:0] sel_data_q;

    logic                   owned;
    logic [1:0]             own_tr;
    logic                   accept;
    logic                   hold;
    logic [CW-1:0]          cnt_inc;
    logic                   others;
    logic                   limit;
    logic                   keep;
    logic [CHANNEL_NUM-1:0] cand;
    logic                   found;
    logic [PW-1:0]          win;
    int                     idx;

    // State, owner index, grant pointer, beat counter and data-phase select.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            last_q     <= PW'(CHANNEL_NUM - 1);
            cnt_q      <= '0;
            sel_data_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            if (hready_in) begin
                sel_data_q <= sel_addr;
            end
        end
    end

    // Decode the current owner into the one-hot address-phase select.
    always_comb begin
        sel_addr = '0;
        if (state_q == ST_OWNED) begin
            sel_addr[owner_q] = 1'b1;
        end
    end

    // Hold / keep / pick decision and next-state computation.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        found   = 1'b0;
        win     = '0;
        idx     = 0;

        owned  = (state_q == ST_OWNED);
        own_tr = htrans[{owner_q, 1'b0} +: 2];
        // NONSEQ (10) and SEQ (11) are real beats; SEQ and BUSY (01) continue a burst.
        accept = owned && own_tr[1];
        hold   = owned && (own_tr[0] || hmastlock[owner_q]);

        // The beat being accepted on this edge already counts toward the limit.
        cnt_inc = (accept && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        others  = |(req & ~sel_addr);
        limit   = owned && (MAX_BEATS != 0) && (int'(cnt_inc) >= MAX_BEATS) && others;
        keep    = owned && req[owner_q] && (own_tr == 2'b10) && !limit;
        cand    = limit ? (req & ~sel_addr) : req;

        for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
            if (RR_EN != 0) begin
                idx = (int'(last_q) + 1 + int'(i)) % CHANNEL_NUM;
            end else begin
                idx = int'(i);
            end
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end

        if (hready_in) begin
            if (hold || keep) begin
                cnt_d = cnt_inc;
            end else if (found) begin
                if (owned && (win == owner_q)) begin
                    cnt_d = cnt_inc;
                end else begin
                    state_d = ST_OWNED;
                    owner_d = win;
                    last_d  = win;
                    cnt_d   = '0;
                end
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
    end

    assign sel_data    = sel_data_q;
    assign owner_valid = |sel_addr;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Scoreboard bench for ahb_slave_arbiter: three parameterisations share one
// stimulus stream; an integer-level reference model predicts outputs.
module tb_ahb_slave_arbiter;

    logic       clk;
    logic       rstn;
    logic [2:0] req;
    logic [5:0] htr;
    logic [2:0] lock;
    logic       hready;

    logic [2:0] sa_a, sd_a, sa_b, sd_b;
    logic [1:0] sa_c, sd_c;
    logic       ov_a, ov_b, ov_c;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         k;
        logic [2:0] sa;
        logic [2:0] sd;
        logic       ov;
    } exp_t;
    exp_t exq[$];

    // Model configuration per instance: channels, round-robin, beat limit.
    int PN[3]  = '{3, 3, 2};
    int PRR[3] = '{1, 0, 1};
    int PMB[3] = '{4, 0, 1};

    // Model state: owner (-1 = none), data-phase owner, last grant, beats.
    int own[3], dat[3], last[3], beats[3];

    ahb_slave_arbiter #(.CHANNEL_NUM(3), .RR_EN(1), .MAX_BEATS(4)) u_a (
        .HCLK(clk), .HRESETn(rstn), .req(req), .htrans(htr), .hmastlock(lock),
        .hready_in(hready), .sel_addr(sa_a), .sel_data(sd_a), .owner_valid(ov_a));

    ahb_slave_arbiter #(.CHANNEL_NUM(3), .RR_EN(0), .MAX_BEATS(0)) u_b (
        .HCLK(clk), .HRESETn(rstn), .req(req), .htrans(htr), .hmastlock(lock),
        .hready_in(hready), .sel_addr(sa_b), .sel_data(sd_b), .owner_valid(ov_b));

    ahb_slave_arbiter #(.CHANNEL_NUM(2), .RR_EN(1), .MAX_BEATS(1)) u_c (
        .HCLK(clk), .HRESETn(rstn), .req(req[1:0]), .htrans(htr[3:0]), .hmastlock(lock[1:0]),
        .hready_in(hready), .sel_addr(sa_c), .sel_data(sd_c), .owner_valid(ov_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] oh(input int x);
        logic [2:0] v;
        v = 3'b000;
        if (x >= 0) v[x] = 1'b1;
        return v;
    endfunction

    function automatic int tr_of(input int m);
        logic [5:0] t;
        t = htr;
        return int'(t[2*m +: 2]);
    endfunction

    // Apply one clock edge of arbitration rules to model instance k.
    task automatic model_step(input int k);
        int  n, o, nxt, tr, c;
        bit  acc, held, others, lim;
        exp_t e;
        n = PN[k];
        if (!rstn) begin
            own[k] = -1; dat[k] = -1; last[k] = n - 1; beats[k] = 0;
        end else if (hready) begin
            o = own[k]; nxt = o; tr = 0;
            acc = 0; held = 0; others = 0; lim = 0;
            if (o >= 0) begin
                tr   = tr_of(o);
                acc  = (tr == 2) || (tr == 3);
                held = (tr == 1) || (tr == 3) || lock[o];
            end
            if (!held) begin
                for (int j = 0; j < n; j++)
                    if (req[j] && j != o) others = 1;
                lim = (o >= 0) && (PMB[k] > 0) && (beats[k] + int'(acc) >= PMB[k]) && others;
                if (o >= 0 && req[o] && tr == 2 && !lim) begin
                    nxt = o;
                end else begin
                    nxt = -1;
                    for (int s = 1; s <= n; s++) begin
                        c = PRR[k] ? (last[k] + s) % n : s - 1;
                        if (nxt < 0 && req[c] && !(lim && c == o)) nxt = c;
                    end
                end
            end
            beats[k] = (nxt == o) ? beats[k] + int'(acc) : 0;
            if (nxt != o && nxt >= 0) last[k] = nxt;
            dat[k] = o;
            own[k] = nxt;
        end
        e.k  = k;
        e.sa = oh(own[k]);
        e.sd = oh(dat[k]);
        e.ov = (own[k] >= 0);
        exq.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
    endtask

    task automatic check(input string name, input int k, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%b want=%b", name, k, $time, act, exp);
        end
    endtask

    // Monitor: compare every predicted response against the DUT mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] a_sa, a_sd;
        logic       a_ov;
        while (exq.size() > 0) begin
            e = exq.pop_front();
            case (e.k)
                0:       begin a_sa = sa_a; a_sd = sd_a; a_ov = ov_a; end
                1:       begin a_sa = sa_b; a_sd = sd_b; a_ov = ov_b; end
                default: begin a_sa = {1'b0, sa_c}; a_sd = {1'b0, sd_c}; a_ov = ov_c; end
            endcase
            check("sel_addr", e.k, a_sa, e.sa);
            check("sel_data", e.k, a_sd, e.sd);
            check("owner_valid", e.k, {2'b00, a_ov}, {2'b00, e.ov});
        end
    end

    function automatic logic [1:0] rand_tr();
        int r;
        r = $urandom_range(99);
        if (r < 25) return 2'b00;
        if (r < 60) return 2'b10;
        if (r < 85) return 2'b11;
        return 2'b01;
    endfunction

    initial begin
        rstn = 1'b0; req = 3'b111; htr = 6'b101010; lock = 3'b000; hready = 1'b1;
        repeat (2) cycle();

        // Continuous single NONSEQ requests from every master.
        rstn = 1'b1;
        repeat (8) cycle();

        // Wait states with requests changing underneath.
        hready = 1'b0;
        req = 3'b010; htr = 6'b001000; cycle();
        req = 3'b100; htr = 6'b110000; cycle();
        req = 3'b000; htr = 6'b000000; cycle();
        hready = 1'b1;
        req = 3'b111; htr = 6'b101010; cycle();

        // Locked back-to-back singles from master 0, then lock released.
        lock = 3'b001;
        repeat (6) cycle();
        lock = 3'b000;
        repeat (4) cycle();

        // Everyone idle.
        req = 3'b000; htr = 6'b000000;
        repeat (3) cycle();

        // Randomized traffic with wait states, locks and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                logic [1:0] t;
                t = rand_tr();
                htr[2*i +: 2] = t;
                req[i] = (t != 2'b00);
                if ($urandom_range(99) < 8) lock[i] = ~lock[i];
            end
            hready = ($urandom_range(99) < 75);
            rstn   = ($urandom_range(199) != 0);
            cycle();
        end

        rstn = 1'b1; hready = 1'b1; req = 3'b000; htr = 6'b000000; lock = 3'b000;
        cycle();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exq.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
